// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves rs1/rs2 through the forwarding network, detects load-use
// hazards, and registers the decoded instruction with its operands for EX.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // upstream decode
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    // register file read port
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    // forwarding sources
    input  logic              ex_fwd_valid,
    input  logic              ex_fwd_is_load,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              mem_fwd_valid,
    input  logic [4:0]        mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    // control
    input  logic              flush,
    // downstream EX
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_adv;
    logic              w_hazard;
    logic              w_capture;
    logic              w_ex_fwd_ok;
    logic              w_mem_fwd_ok;
    logic              w_wb_fwd_ok;
    logic              w_cnt_sat;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;

    // Producers writing x0 never forward; loads in EX have no data yet.
    assign w_ex_fwd_ok  = ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_rd != 5'd0);
    assign w_mem_fwd_ok = mem_fwd_valid && (mem_fwd_rd != 5'd0);
    assign w_wb_fwd_ok  = wb_we && (wb_rd != 5'd0);

    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_val
    );
        logic [XLEN-1:0] val;
        val = rf_val;
        if (src == 5'd0) begin
            val = '0;
        end else if (w_ex_fwd_ok && (ex_fwd_rd == src)) begin
            val = ex_fwd_data;
        end else if (w_mem_fwd_ok && (mem_fwd_rd == src)) begin
            val = mem_fwd_data;
        end else if (w_wb_fwd_ok && (wb_rd == src)) begin
            val = wb_data;
        end
        return val;
    endfunction

    assign rf_raddr1  = in_rs1;
    assign rf_raddr2  = in_rs2;
    assign w_rs1_data = resolve(in_rs1, rf_rdata1);
    assign w_rs2_data = resolve(in_rs2, rf_rdata2);

    assign w_hazard = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != 5'd0) &&
                      ((in_use_rs1 && (in_rs1 == ex_fwd_rd)) ||
                       (in_use_rs2 && (in_rs2 == ex_fwd_rd)));

    assign w_adv     = !r_valid || out_ready;
    assign in_ready  = w_adv && !w_hazard && !flush;
    assign w_capture = w_adv && in_valid && !w_hazard && !flush;
    assign w_cnt_sat = (r_stall_cnt == {CNT_W{1'b1}});

    // Pipeline register; flush beats advance, a stalled EX freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_rd       <= in_rd;
                r_pc       <= in_pc;
                r_imm      <= in_imm;
                r_ctrl     <= in_ctrl;
            end
        end
    end

    // Load-use stall counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && w_adv && !flush && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid    = r_valid;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_rd       = r_rd;
    assign out_pc       = r_pc;
    assign out_imm      = r_imm;
    assign out_ctrl     = r_ctrl;
    assign stall_cnt    = r_stall_cnt;

endmodule
